// File: rtl/dma_endpoint_pkg.sv
// Shared types and constants for the DMA I/O endpoint.
package dma_endpoint_pkg;

    localparam int unsigned EP_DEPTH_DEF = 16;
    localparam int unsigned EP_DW_DEF    = 8;

    // Endpoint handshake states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        XFER = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } ep_state_e;

    // Bit positions inside the sticky ERR vector
    localparam int unsigned ERR_OVERFLOW  = 0;
    localparam int unsigned ERR_UNDERFLOW = 1;

    // Transfer direction encodings
    localparam logic DIR_DEV2MEM = 1'b1;
    localparam logic DIR_MEM2DEV = 1'b0;

endpackage

// File: rtl/dma_ep_fifo.sv
// Synchronous FIFO between the DMA bus side and the local stream side.
module dma_ep_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [DW-1:0]          push_data_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Occupancy update; simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/dma_io_endpoint.sv
// Peripheral-side DREQ/DACK responder: FSM, strobe edge detect, DB mux, sticky status.
module dma_io_endpoint
    import dma_endpoint_pkg::*;
#(
    parameter int unsigned DEPTH = EP_DEPTH_DEF,
    parameter int unsigned DW    = EP_DW_DEF
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          DIR,
    input  logic          DEMAND,
    input  logic          START,
    output logic          DREQ,
    input  logic          DACK,
    input  logic          IOR_N,
    input  logic          IOW_N,
    input  logic          EOP_N,
    input  logic [DW-1:0] DB_IN,
    output logic [DW-1:0] DB_OUT,
    output logic          DB_OE,
    input  logic          SRC_VALID,
    output logic          SRC_READY,
    input  logic [DW-1:0] SRC_DATA,
    output logic          SNK_VALID,
    input  logic          SNK_READY,
    output logic [DW-1:0] SNK_DATA,
    output logic          TC_DONE,
    output logic [1:0]    ERR
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    ep_state_e     state_q, state_d;
    logic          dreq_q, dreq_d;
    logic          enabled_q, enabled_d;
    logic          tc_done_q, tc_done_d;
    logic [1:0]    err_q, err_d;
    logic          start_pend_q, start_pend_d;
    logic          dir_q, demand_q;
    logic          ior_prev_q, iow_prev_q;
    logic [DW-1:0] hold_q;

    logic          dev2mem, mem2dev;
    logic          legal_rd, legal_wr, both_low, wrong_dir;
    logic          ior_rise, iow_rise, active_low, active_rise;
    logic          start_fire, ready_cond, eop_hit;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DW-1:0] fifo_din, fifo_head;
    logic [CW-1:0] fifo_count;

    // Strobe qualification under DACK; illegal combinations never touch the FIFO
    assign dev2mem     = (dir_q == DIR_DEV2MEM);
    assign mem2dev     = (dir_q == DIR_MEM2DEV);
    assign legal_rd    = DACK & ~IOR_N & IOW_N & dev2mem;
    assign legal_wr    = DACK & ~IOW_N & IOR_N & mem2dev;
    assign both_low    = DACK & ~IOR_N & ~IOW_N;
    assign wrong_dir   = DACK & ((~IOR_N & IOW_N & mem2dev) | (~IOW_N & IOR_N & dev2mem));
    assign ior_rise    = DACK & dev2mem & ~ior_prev_q & IOR_N & IOW_N;
    assign iow_rise    = DACK & mem2dev & ~iow_prev_q & IOW_N & IOR_N;
    assign active_low  = dev2mem ? legal_rd : legal_wr;
    assign active_rise = dev2mem ? ior_rise : iow_rise;
    assign eop_hit     = DACK & ~EOP_N;
    // A START arriving mid-strobe is held back until the strobe has completed
    assign start_fire  = (START | start_pend_q) & (state_q != XFER);
    assign ready_cond  = dev2mem ? (fifo_count != '0) : (fifo_count < CW'(DEPTH));

    // FIFO hookup: bus side pops/pushes by direction, local side takes the other end
    assign fifo_push = dev2mem ? SRC_VALID : iow_rise;
    assign fifo_din  = dev2mem ? SRC_DATA  : hold_q;
    assign fifo_pop  = dev2mem ? ior_rise  : SNK_READY;

    dma_ep_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_ni      (RESET_N),
        .push_i      (fifo_push),
        .push_data_i (fifo_din),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Bus drive follows the read strobe directly so DB turns around with IOR_N
    assign DB_OE     = legal_rd;
    assign DB_OUT    = legal_rd ? (fifo_empty ? '1 : fifo_head) : '0;
    assign SRC_READY = dev2mem & ~fifo_full;
    assign SNK_VALID = mem2dev & ~fifo_empty;
    assign SNK_DATA  = fifo_head;
    assign DREQ      = dreq_q;
    assign TC_DONE   = tc_done_q;
    assign ERR       = err_q;

    // Next-state, request and sticky-status logic
    always_comb begin
        state_d      = state_q;
        dreq_d       = dreq_q;
        enabled_d    = enabled_q | start_fire;
        tc_done_d    = tc_done_q & ~start_fire;
        err_d        = start_fire ? 2'b00 : err_q;
        start_pend_d = (state_q == XFER) ? (start_pend_q | START) : 1'b0;

        err_d[ERR_UNDERFLOW] = err_d[ERR_UNDERFLOW] | (legal_rd & fifo_empty);
        err_d[ERR_OVERFLOW]  = err_d[ERR_OVERFLOW] | both_low | wrong_dir
                               | (iow_rise & fifo_full);

        case (state_q)
            IDLE: begin
                dreq_d = 1'b0;
                if (enabled_q && ready_cond && !tc_done_q) begin
                    state_d = REQ;
                    dreq_d  = 1'b1;
                end
            end
            REQ: begin
                dreq_d = 1'b1;
                if (active_low) state_d = XFER;
            end
            XFER: begin
                dreq_d = 1'b1;
                if (active_rise) begin
                    state_d = GAP;
                    dreq_d  = demand_q;
                end
            end
            GAP: begin
                if (demand_q && ready_cond && !tc_done_q) begin
                    state_d = REQ;
                    dreq_d  = 1'b1;
                end else begin
                    dreq_d = 1'b0;
                    if (!DACK) state_d = IDLE;
                end
            end
            DONE: begin
                dreq_d = 1'b0;
                if (start_fire) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                dreq_d  = 1'b0;
            end
        endcase

        if (eop_hit) begin
            state_d   = DONE;
            dreq_d    = 1'b0;
            tc_done_d = 1'b1;
        end
    end

    // Control and status registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            dreq_q       <= 1'b0;
            enabled_q    <= 1'b0;
            tc_done_q    <= 1'b0;
            err_q        <= 2'b00;
            start_pend_q <= 1'b0;
            dir_q        <= DIR_MEM2DEV;
            demand_q     <= 1'b0;
            ior_prev_q   <= 1'b1;
            iow_prev_q   <= 1'b1;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            dreq_q       <= dreq_d;
            enabled_q    <= enabled_d;
            tc_done_q    <= tc_done_d;
            err_q        <= err_d;
            start_pend_q <= start_pend_d;
            ior_prev_q   <= IOR_N;
            iow_prev_q   <= IOW_N;
            if (state_q == IDLE) begin
                dir_q    <= DIR;
                demand_q <= DEMAND;
            end
            if (legal_wr) hold_q <= DB_IN;
        end
    end

endmodule

// File: tb/tb_dma_io_endpoint.sv
// Self-checking bench for dma_io_endpoint acting as a simple 8237 bus master.
module tb_dma_io_endpoint;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 8;

    logic          CLK = 1'b0;
    logic          RESET_N, DIR, DEMAND, START, DACK, IOR_N, IOW_N, EOP_N;
    logic [DW-1:0] DB_IN, SRC_DATA;
    logic          SRC_VALID, SNK_READY;
    logic          DREQ, DB_OE, SRC_READY, SNK_VALID, TC_DONE;
    logic [DW-1:0] DB_OUT, SNK_DATA;
    logic [1:0]    ERR;

    int n_tests = 0;
    int n_fail  = 0;

    dma_io_endpoint #(.DEPTH(DEPTH), .DW(DW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DIR(DIR), .DEMAND(DEMAND), .START(START),
        .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
        .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
        .SRC_VALID(SRC_VALID), .SRC_READY(SRC_READY), .SRC_DATA(SRC_DATA),
        .SNK_VALID(SNK_VALID), .SNK_READY(SNK_READY), .SNK_DATA(SNK_DATA),
        .TC_DONE(TC_DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       dir, dack, ior_n, iow_n;
        logic       exp_oe;
        logic [7:0] exp_db;
        logic [1:0] exp_err;
    } vec_t;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1; START = 1'b0;
        SRC_VALID = 1'b0; SNK_READY = 1'b0; DB_IN = '0; SRC_DATA = '0;
    endtask

    task automatic do_reset(input logic dir, input logic demand);
        idle_bus();
        DIR = dir; DEMAND = demand;
        RESET_N = 1'b0;
        tick(); tick();
        RESET_N = 1'b1;
        tick(); tick();
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic src_push(input logic [7:0] d);
        SRC_VALID = 1'b1; SRC_DATA = d;
        tick();
        SRC_VALID = 1'b0;
    endtask

    // One IOR_N strobe of two low cycles; returns what the device drove mid-strobe
    task automatic dma_read(output logic [7:0] d, output logic oe);
        DACK = 1'b1; IOR_N = 1'b0;
        #1;
        d = DB_OUT; oe = DB_OE;
        tick(); tick();
        IOR_N = 1'b1;
        tick();
    endtask

    task automatic dma_write(input logic [7:0] d);
        DACK = 1'b1; DB_IN = d; IOW_N = 1'b0;
        tick(); tick();
        IOW_N = 1'b1;
        tick();
    endtask

    task automatic wait_dreq(input logic v, input string name);
        int n = 0;
        while (DREQ !== v && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(DREQ), 32'(v));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       vt [8];
        logic [7:0] d, x;
        logic       oe;
        logic [7:0] q [$];
        logic [7:0] exp_b;
        int         popped, iter;

        vt[0] = '{dir:1'b1, dack:1'b1, ior_n:1'b0, iow_n:1'b1, exp_oe:1'b1, exp_db:8'hFF, exp_err:2'b10};
        vt[1] = '{dir:1'b1, dack:1'b0, ior_n:1'b0, iow_n:1'b1, exp_oe:1'b0, exp_db:8'h00, exp_err:2'b00};
        vt[2] = '{dir:1'b1, dack:1'b1, ior_n:1'b1, iow_n:1'b0, exp_oe:1'b0, exp_db:8'h00, exp_err:2'b01};
        vt[3] = '{dir:1'b1, dack:1'b1, ior_n:1'b0, iow_n:1'b0, exp_oe:1'b0, exp_db:8'h00, exp_err:2'b01};
        vt[4] = '{dir:1'b0, dack:1'b1, ior_n:1'b1, iow_n:1'b0, exp_oe:1'b0, exp_db:8'h00, exp_err:2'b00};
        vt[5] = '{dir:1'b0, dack:1'b1, ior_n:1'b0, iow_n:1'b1, exp_oe:1'b0, exp_db:8'h00, exp_err:2'b01};
        vt[6] = '{dir:1'b0, dack:1'b0, ior_n:1'b0, iow_n:1'b0, exp_oe:1'b0, exp_db:8'h00, exp_err:2'b00};
        vt[7] = '{dir:1'b1, dack:1'b1, ior_n:1'b1, iow_n:1'b1, exp_oe:1'b0, exp_db:8'h00, exp_err:2'b00};

        // Reset values
        idle_bus();
        DIR = 1'b0; DEMAND = 1'b0; RESET_N = 1'b0;
        tick();
        chk("rst_dreq", 32'(DREQ), 32'd0);
        chk("rst_oe", 32'(DB_OE), 32'd0);
        chk("rst_dbout", 32'(DB_OUT), 32'd0);
        chk("rst_tc", 32'(TC_DONE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_snk_valid", 32'(SNK_VALID), 32'd0);

        // Strobe decode table
        for (int i = 0; i < 8; i++) begin
            do_reset(vt[i].dir, 1'b0);
            DACK = vt[i].dack; IOR_N = vt[i].ior_n; IOW_N = vt[i].iow_n;
            #1;
            chk($sformatf("vec%0d_oe", i), 32'(DB_OE), 32'(vt[i].exp_oe));
            chk($sformatf("vec%0d_db", i), 32'(DB_OUT), 32'(vt[i].exp_db));
            tick();
            chk($sformatf("vec%0d_err", i), 32'(ERR), 32'(vt[i].exp_err));
            idle_bus();
            tick();
        end

        // Single mode device->memory, three bytes
        do_reset(1'b1, 1'b0);
        src_push(8'hA5); src_push(8'h5A); src_push(8'hC3);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       exp_b = 8'hA5;
                1:       exp_b = 8'h5A;
                default: exp_b = 8'hC3;
            endcase
            wait_dreq(1'b1, "single_dreq");
            dma_read(d, oe);
            chk("single_data", 32'(d), 32'(exp_b));
            chk("single_oe", 32'(oe), 32'd1);
            chk("single_gap_dreq", 32'(DREQ), 32'd0);
            DACK = 1'b0;
        end
        repeat (5) tick();
        chk("single_empty_noreq", 32'(DREQ), 32'd0);
        chk("single_err", 32'(ERR), 32'd0);

        // Demand mode memory->device, fill to full then overflow
        do_reset(1'b0, 1'b1);
        pulse_start();
        wait_dreq(1'b1, "demand_first");
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("demand_hold%0d", i), 32'(DREQ), 32'd1);
            dma_write(8'(i));
        end
        tick();
        chk("demand_full_drop", 32'(DREQ), 32'd0);
        chk("demand_err_clean", 32'(ERR), 32'd0);
        dma_write(8'h11);
        chk("overflow_err", 32'(ERR), 32'b01);
        DACK = 1'b0;
        tick();
        SNK_READY = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("snk_valid", 32'(SNK_VALID), 32'd1);
            chk("snk_data", 32'(SNK_DATA), 32'(i));
            tick();
        end
        chk("snk_drained", 32'(SNK_VALID), 32'd0);
        SNK_READY = 1'b0;

        // Terminal count on the second of four transfers
        do_reset(1'b1, 1'b1);
        src_push(8'h11); src_push(8'h22); src_push(8'h33); src_push(8'h44);
        pulse_start();
        wait_dreq(1'b1, "eop_dreq");
        dma_read(d, oe);
        chk("eop_b1", 32'(d), 32'h11);
        IOR_N = 1'b0;
        #1;
        chk("eop_b2", 32'(DB_OUT), 32'h22);
        tick(); tick();
        IOR_N = 1'b1; EOP_N = 1'b0;
        tick();
        EOP_N = 1'b1;
        chk("eop_tc", 32'(TC_DONE), 32'd1);
        chk("eop_dreq_drop", 32'(DREQ), 32'd0);
        DACK = 1'b0;
        repeat (4) tick();
        chk("done_hold", 32'(DREQ), 32'd0);
        pulse_start();
        chk("start_clears_tc", 32'(TC_DONE), 32'd0);
        wait_dreq(1'b1, "rearm");
        dma_read(d, oe);
        chk("eop_b3", 32'(d), 32'h33);
        dma_read(d, oe);
        chk("eop_b4", 32'(d), 32'h44);
        DACK = 1'b0;
        repeat (3) tick();
        chk("eop_two_left", 32'(DREQ), 32'd0);

        // Read from an empty FIFO
        do_reset(1'b1, 1'b0);
        DACK = 1'b1; IOR_N = 1'b0;
        #1;
        chk("empty_oe", 32'(DB_OE), 32'd1);
        chk("empty_db", 32'(DB_OUT), 32'hFF);
        tick();
        chk("empty_err", 32'(ERR), 32'b10);
        IOR_N = 1'b1;
        tick();
        DACK = 1'b0;
        tick();
        src_push(8'hAB);
        dma_read(d, oe);
        chk("empty_no_pop", 32'(d), 32'hAB);
        DACK = 1'b0;

        // Asynchronous reset in the middle of a read strobe
        do_reset(1'b1, 1'b0);
        src_push(8'h01); src_push(8'h02); src_push(8'h03);
        pulse_start();
        wait_dreq(1'b1, "rst_mid_dreq");
        DACK = 1'b1; IOR_N = 1'b0;
        tick();
        chk("rst_mid_oe_before", 32'(DB_OE), 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("rst_mid_oe", 32'(DB_OE), 32'd0);
        chk("rst_mid_dreq_low", 32'(DREQ), 32'd0);
        DACK = 1'b0; IOR_N = 1'b1;
        tick();
        RESET_N = 1'b1;
        tick(); tick();
        chk("rst_after_dreq", 32'(DREQ), 32'd0);
        DACK = 1'b1; IOR_N = 1'b0;
        #1;
        chk("rst_after_empty", 32'(DB_OUT), 32'hFF);
        IOR_N = 1'b1; DACK = 1'b0;
        tick();

        // Push and pop on the same edge at count 5
        do_reset(1'b1, 1'b0);
        q.delete();
        for (int i = 0; i < 5; i++) begin
            x = 8'($urandom);
            src_push(x);
            q.push_back(x);
        end
        DACK = 1'b1; IOR_N = 1'b0;
        #1;
        chk("pp_head", 32'(DB_OUT), 32'(q[0]));
        tick(); tick();
        x = 8'($urandom);
        IOR_N = 1'b1; SRC_VALID = 1'b1; SRC_DATA = x;
        tick();
        SRC_VALID = 1'b0; DACK = 1'b0;
        void'(q.pop_front());
        q.push_back(x);
        for (int i = 0; i < 5; i++) begin
            dma_read(d, oe);
            exp_b = q.pop_front();
            chk("pp_drain", 32'(d), 32'(exp_b));
        end
        dma_read(d, oe);
        chk("pp_then_empty", 32'(d), 32'hFF);
        DACK = 1'b0;

        // Randomised traffic against a queue model, wrapping the pointers
        do_reset(1'b1, 1'b1);
        q.delete();
        popped = 0;
        iter = 0;
        while (popped < 40 && iter < 1000) begin
            iter++;
            if ($urandom_range(0, 2) != 0) begin
                chk("rnd_ready", 32'(SRC_READY), 32'(q.size() < DEPTH));
                x = 8'($urandom);
                src_push(x);
                if (q.size() < DEPTH) q.push_back(x);
            end else if (q.size() > 0) begin
                dma_read(d, oe);
                DACK = 1'b0;
                exp_b = q.pop_front();
                chk("rnd_data", 32'(d), 32'(exp_b));
                popped++;
            end
        end
        chk("rnd_progress", 32'(popped >= 40), 32'd1);
        while (q.size() > 0) begin
            dma_read(d, oe);
            DACK = 1'b0;
            exp_b = q.pop_front();
            chk("rnd_tail", 32'(d), 32'(exp_b));
        end
        dma_read(d, oe);
        DACK = 1'b0;
        chk("rnd_final_empty", 32'(d), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
